ram_loader: RTL and testbench
=============================

// Module: ram_loader
// PURPOSE
//  Parametrised memory initialiser: after reset, or on request, copies an IMG_WORDS-word ROM image
//  (COPY) or writes a constant (FILL) into a RAM window starting at a programmable base. Then hands
//  the RAM to an external port with a ready handshake. Generalises the fixed 76800-word copier:
//  - tolerates any ROM read latency
//  - supports re-load and base offset
// PARAMETERS
//  DATA_W     8      RAM/ROM word width
//  ADDR_W     19     RAM address width
//  SRC_W      17     ROM address width
//  IMG_WORDS  76800  words per image; 1..2^SRC_W
//  ROM_LAT    1      ROM clock-to-q latency in cycles; 1..3
// PORTS
//  clock       in   1       system clock
//  reset       in   1       async, active-high; aborts and restarts an auto COPY at base 0
//  start       in   1       1-cycle request to begin a load; ignored while busy
//  mode        in   1       0=COPY, 1=FILL; sampled with start
//  fill_value  in   DATA_W  FILL word; sampled with start
//  dst_base    in   ADDR_W  RAM base address; sampled with start
//  busy        out  1       load in progress
//  done        out  1       1-cycle pulse after the last RAM write
//  init_done   out  1       high from done until next start or reset
//  ext_addr    in   ADDR_W  external RAM address
//  ext_data    in   DATA_W  external write data
//  ext_wren    in   1       external write enable; honoured only when ext_ready=1
//  ext_ready   out  1       =!busy; external port owns the RAM
//  q_out       out  DATA_W  =ram_q; RAM read data
//  rom_addr    out  SRC_W   ROM read address
//  rom_q       in   DATA_W  ROM data, valid ROM_LAT cycles after rom_addr
//  ram_addr    out  ADDR_W  RAM address, registered
//  ram_data    out  DATA_W  RAM write data, registered
//  ram_wren    out  1       RAM write enable, registered
//  ram_q       in   DATA_W  RAM read data
// BEHAVIOUR
//  Reset values:
//  - state=ISSUE, mode=COPY, base=0, idx=0
//  - busy=1, done=0, init_done=0, ext_ready=0
//  - rom_addr=0, ram_addr=0, ram_data=0, ram_wren=0
//  - valid pipe cleared
//  FSM IDLE->ISSUE->DRAIN->DONE->IDLE:
//  - IDLE: ext port drives ram_* (one register stage). start -> latch mode/fill/base, idx=0,
//    init_done=0, ->ISSUE.
//  - ISSUE: one word per cycle.
//    - COPY: rom_addr=idx; tag enters a ROM_LAT-deep valid/addr pipe (load_pipe).
//    - FILL: write base+idx directly; ROM unused.
//    - At idx==IMG_WORDS-1: ->DRAIN (COPY) or ->DONE (FILL); otherwise idx++.
//  - DRAIN: hold for ROM_LAT cycles until the pipe empties; pipe outputs keep writing. Then ->DONE.
//  - DONE: done=1 and init_done=1 for one cycle; ->IDLE. busy drops the same cycle.
//  - busy=1 in ISSUE/DRAIN/DONE.
//  RAM write (COPY): when the pipe-out valid=1, register ram_addr=base+tag, ram_data=rom_q, ram_wren=1.
//  Address arithmetic: base+idx is ADDR_W wide, modulo 2^ADDR_W (wraps, no error).
//  Timing:
//  - Exactly IMG_WORDS writes per load, strictly ascending offset order, no gaps in ISSUE.
//  - COPY latency, start to done: IMG_WORDS+ROM_LAT+2 cycles.
//  - FILL latency, start to done: IMG_WORDS+1 cycles.
//  While busy: ext_wren and ext_addr are ignored (no external write ever lands); q_out is undefined.
//  start while busy: dropped, no queueing. start and reset together: reset wins.
//  reset mid-load: immediate abort; RAM contents are partial; auto COPY restarts after release.
// STRUCTURE
//  Package ram_loader_pkg:
//  - state enum {IDLE,ISSUE,DRAIN,DONE}
//  - MODE_COPY/MODE_FILL constants
//  Sub-module load_pipe: ROM_LAT-stage shift of {valid, SRC_W tag}; async reset clears valid.
//  Rom/Ram instances stay outside; this block exposes their ports.
// TESTING  (IMG_WORDS=16, ADDR_W=8, ROM_LAT=2, ROM[i]=i^8'hA5)
//  1. Release reset -> 16 writes RAM[i]=i^A5 for i=0..15; done pulse at cycle 20; init_done=1; ext_ready=1.
//  2. start, mode=FILL, fill_value=8'h3C, dst_base=8'h40 -> RAM[40..4F]=3C; done after 17 cycles; RAM[0..F] unchanged.
//  3. COPY with dst_base=8'hF8 -> writes F8..FF then wraps 00..07; RAM[F8]=A5, RAM[07]=AA.
//  4. ext_wren=1, ext_addr=8'h05 held throughout a load -> no write to 05 while busy;
//     write lands on the first cycle after ext_ready=1.
//  5. Second start during ISSUE -> ignored; exactly 16 writes and one done pulse.
//  6. reset asserted at word 7 of a FILL -> all outputs at reset values asynchronously;
//     auto COPY completes; RAM[0..F]=i^A5.

Source files
------------

// File: rtl/ram_loader_pkg.sv
// Shared types and constants for the RAM initialiser.
package ram_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ram_loader_if.sv
// Bundle of control, external-port, ROM and RAM signals around the loader.
interface ram_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 19,
    parameter int SRC_W  = 17
);
    // control
    logic              start;
    logic              mode;
    logic [DATA_W-1:0] fill_value;
    logic [ADDR_W-1:0] dst_base;
    logic              busy;
    logic              done;
    logic              init_done;
    // external RAM port
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_data;
    logic              ext_wren;
    logic              ext_ready;
    logic [DATA_W-1:0] q_out;
    // ROM side
    logic [SRC_W-1:0]  rom_addr;
    logic [DATA_W-1:0] rom_q;
    // RAM side
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    // The loader itself.
    modport slave (
        input  start, mode, fill_value, dst_base,
        input  ext_addr, ext_data, ext_wren,
        input  rom_q, ram_q,
        output busy, done, init_done, ext_ready, q_out,
        output rom_addr, ram_addr, ram_data, ram_wren
    );

    // The environment: controller, external user, ROM and RAM.
    modport master (
        output start, mode, fill_value, dst_base,
        output ext_addr, ext_data, ext_wren,
        output rom_q, ram_q,
        input  busy, done, init_done, ext_ready, q_out,
        input  rom_addr, ram_addr, ram_data, ram_wren
    );

endinterface

// File: rtl/ram_loader_load_pipe.sv
// Delay line that carries {valid, source index} alongside the ROM read latency.
module load_pipe #(
    parameter int SRC_W = 17,
    parameter int DEPTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [SRC_W-1:0] in_tag,
    output logic             out_valid,
    output logic [SRC_W-1:0] out_tag
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic             valid_reg;
            logic [SRC_W-1:0] tag_reg;
            logic             valid_in;
            logic [SRC_W-1:0] tag_in;

            if (gi == 0) begin : g_head
                assign valid_in = in_valid;
                assign tag_in   = in_tag;
            end else begin : g_body
                assign valid_in = g_stage[gi-1].valid_reg;
                assign tag_in   = g_stage[gi-1].tag_reg;
            end

            // Valid bit is cleared by reset so an aborted load leaves no stray writes.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                end else begin
                    valid_reg <= valid_in;
                end
            end

            // Tag only matters when valid is set, so it needs no reset.
            always_ff @(posedge clock) begin
                tag_reg <= tag_in;
            end
        end
    endgenerate

    assign out_valid = g_stage[DEPTH-1].valid_reg;
    assign out_tag   = g_stage[DEPTH-1].tag_reg;

endmodule

// File: rtl/ram_loader.sv
// RAM initialiser: copies a ROM image or writes a constant into a RAM window,
// then hands the RAM to the external port.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 19,
    parameter int SRC_W     = 17,
    parameter int IMG_WORDS = 76800,
    parameter int ROM_LAT   = 1
) (
    input  logic       clock,
    input  logic       reset,
    ram_loader_if.slave bus
);

    localparam logic [SRC_W-1:0] LAST_IDX   = SRC_W'(IMG_WORDS - 1);
    // The registered rom_addr adds one stage in front of the ROM latency.
    localparam logic [2:0]       DRAIN_LAST = 3'(ROM_LAT);

    state_t            state_reg;
    state_t            state_next;
    logic [SRC_W-1:0]  idx_reg;
    logic              mode_reg;
    logic [DATA_W-1:0] fill_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [2:0]        drain_reg;
    logic              init_done_reg;
    logic [SRC_W-1:0]  rom_addr_reg;
    logic              rom_vld_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic [DATA_W-1:0] ram_data_reg;
    logic              ram_wren_reg;
    logic              pipe_valid;
    logic [SRC_W-1:0]  pipe_tag;
    logic              last_word;

    assign last_word = (idx_reg == LAST_IDX);

    load_pipe #(
        .SRC_W (SRC_W),
        .DEPTH (ROM_LAT)
    ) u_load_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (rom_vld_reg),
        .in_tag    (rom_addr_reg),
        .out_valid (pipe_valid),
        .out_tag   (pipe_tag)
    );

    // State register; reset lands in ISSUE so an auto COPY starts on release.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ISSUE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = ISSUE;
            ISSUE:   if (last_word) state_next = (mode_reg == MODE_FILL) ? DONE : DRAIN;
            DRAIN:   if (drain_reg == DRAIN_LAST) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from state, plus the registered port drivers.
    always_comb begin
        bus.busy      = (state_reg != IDLE);
        bus.done      = (state_reg == DONE);
        bus.ext_ready = (state_reg == IDLE);
        bus.init_done = init_done_reg;
        bus.q_out     = bus.ram_q;
        bus.rom_addr  = rom_addr_reg;
        bus.ram_addr  = ram_addr_reg;
        bus.ram_data  = ram_data_reg;
        bus.ram_wren  = ram_wren_reg;
    end

    // Load parameters, word index, ROM issue and drain counting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_reg       <= '0;
            mode_reg      <= MODE_COPY;
            fill_reg      <= '0;
            base_reg      <= '0;
            drain_reg     <= '0;
            init_done_reg <= 1'b0;
            rom_addr_reg  <= '0;
            rom_vld_reg   <= 1'b0;
        end else begin
            rom_vld_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        mode_reg      <= bus.mode;
                        fill_reg      <= bus.fill_value;
                        base_reg      <= bus.dst_base;
                        idx_reg       <= '0;
                        init_done_reg <= 1'b0;
                    end
                end
                ISSUE: begin
                    drain_reg <= '0;
                    if (mode_reg == MODE_COPY) begin
                        rom_addr_reg <= idx_reg;
                        rom_vld_reg  <= 1'b1;
                    end
                    if (!last_word) begin
                        idx_reg <= idx_reg + SRC_W'(1);
                    end
                end
                DRAIN: begin
                    drain_reg <= drain_reg + 3'd1;
                end
                default: begin
                end
            endcase
            if (state_next == DONE) begin
                init_done_reg <= 1'b1;
            end
        end
    end

    // RAM port register: external port when idle, otherwise FILL words or ROM data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_addr_reg <= '0;
            ram_data_reg <= '0;
            ram_wren_reg <= 1'b0;
        end else if (state_reg == IDLE) begin
            ram_addr_reg <= bus.ext_addr;
            ram_data_reg <= bus.ext_data;
            ram_wren_reg <= bus.ext_wren;
        end else if (state_reg == ISSUE && mode_reg == MODE_FILL) begin
            ram_addr_reg <= base_reg + ADDR_W'(idx_reg);
            ram_data_reg <= fill_reg;
            ram_wren_reg <= 1'b1;
        end else begin
            ram_wren_reg <= pipe_valid;
            if (pipe_valid) begin
                ram_addr_reg <= base_reg + ADDR_W'(pipe_tag);
                ram_data_reg <= bus.rom_q;
            end
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: ROM and RAM models, write log, directed and random loads.
module tb_ram_loader;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 8;
    localparam int SRC_W     = 5;
    localparam int IMG_WORDS = 16;
    localparam int ROM_LAT   = 2;

    logic clock;
    logic reset;

    ram_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SRC_W(SRC_W)) bus ();

    ram_loader #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .SRC_W     (SRC_W),
        .IMG_WORDS (IMG_WORDS),
        .ROM_LAT   (ROM_LAT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int done_count = 0;

    logic [7:0] mem     [256];
    logic [7:0] exp_mem [256];
    logic [7:0] rom_d1, rom_d2;
    logic [7:0] wa_q [$];
    logic [7:0] wd_q [$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ROM with ROM_LAT=2 cycles clock-to-q: image word i = i ^ A5.
    always @(posedge clock) begin
        rom_d1 <= {3'b000, bus.rom_addr} ^ 8'hA5;
        rom_d2 <= rom_d1;
    end
    assign bus.rom_q = rom_d2;

    // RAM model and write log.
    always @(posedge clock) begin
        if (bus.ram_wren === 1'b1) begin
            mem[bus.ram_addr] <= bus.ram_data;
            wa_q.push_back(bus.ram_addr);
            wd_q.push_back(bus.ram_data);
        end
        bus.ram_q <= mem[bus.ram_addr];
        if (bus.done === 1'b1) done_count <= done_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      32'(bus.busy),      32'd1);
        check({tag, "_done"},      32'(bus.done),      32'd0);
        check({tag, "_init_done"}, 32'(bus.init_done), 32'd0);
        check({tag, "_ext_ready"}, 32'(bus.ext_ready), 32'd0);
        check({tag, "_rom_addr"},  32'(bus.rom_addr),  32'd0);
        check({tag, "_ram_addr"},  32'(bus.ram_addr),  32'd0);
        check({tag, "_ram_data"},  32'(bus.ram_data),  32'd0);
        check({tag, "_ram_wren"},  32'(bus.ram_wren),  32'd0);
    endtask

    // Checks after done: log, handover, optional held external write, RAM image.
    task automatic post_load(input logic m, input logic [7:0] f, input logic [7:0] b,
                             input int dc0, input bit ext_hold, input string tag);
        int mism;
        logic [7:0] ea, ed;
        @(negedge clock);
        check({tag, "_ext_ready"}, 32'(bus.ext_ready), 32'd1);
        check({tag, "_init_hold"}, 32'(bus.init_done), 32'd1);
        check({tag, "_wr_count"}, 32'(wa_q.size()), 32'(IMG_WORDS));
        mism = 0;
        for (int i = 0; i < IMG_WORDS; i++) begin
            ea = b + 8'(i);
            ed = m ? f : (8'(i) ^ 8'hA5);
            if (i < wa_q.size()) begin
                if (wa_q[i] !== ea || wd_q[i] !== ed) mism++;
            end
            exp_mem[ea] = ed;
        end
        check({tag, "_wr_order"}, 32'(mism), 32'd0);
        if (ext_hold) check({tag, "_ext_blocked"}, 32'(mem[8'h05]), 32'(exp_mem[8'h05]));
        @(negedge clock);
        if (ext_hold) begin
            check({tag, "_ext_wren"}, 32'(bus.ram_wren), 32'd1);
            check({tag, "_ext_addr"}, 32'(bus.ram_addr), 32'h05);
        end
        bus.ext_wren = 1'b0;
        @(negedge clock);
        if (ext_hold) begin
            exp_mem[8'h05] = 8'h77;
            check({tag, "_ext_landed"}, 32'(mem[8'h05]), 32'h77);
        end
        check({tag, "_one_done"}, 32'(done_count - dc0), 32'd1);
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
        mism = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== exp_mem[a]) mism++;
        check({tag, "_ram_image"}, 32'(mism), 32'd0);
        $display("load %s mode=%0d fill=%02h base=%02h writes=%0d", tag, m, f, b, wa_q.size());
    endtask

    task automatic run_load(input logic m, input logic [7:0] f, input logic [7:0] b,
                            input int restart_at, input bit ext_hold, input string tag);
        int n;
        int dc0;
        int lat_exp;
        lat_exp = m ? IMG_WORDS + 1 : IMG_WORDS + ROM_LAT + 2;
        wa_q.delete();
        wd_q.delete();
        dc0 = done_count;
        @(negedge clock);
        bus.start = 1'b1;
        bus.mode = m;
        bus.fill_value = f;
        bus.dst_base = b;
        n = 0;
        do begin
            @(negedge clock);
            n++;
            bus.start = 1'b0;
            if (n == 1) begin
                check({tag, "_busy"}, 32'(bus.busy), 32'd1);
                check({tag, "_init_clr"}, 32'(bus.init_done), 32'd0);
                if (ext_hold) begin
                    bus.ext_addr = 8'h05;
                    bus.ext_data = 8'h77;
                    bus.ext_wren = 1'b1;
                end
            end
            if (n == restart_at) begin
                bus.start = 1'b1;
                bus.mode = ~m;
                bus.fill_value = ~f;
                bus.dst_base = b + 8'h10;
            end
        end while (bus.done !== 1'b1 && n < 200);
        check({tag, "_latency"}, 32'(n), 32'(lat_exp));
        check({tag, "_init_done"}, 32'(bus.init_done), 32'd1);
        post_load(m, f, b, dc0, ext_hold, tag);
    endtask

    // Release reset and follow the automatic COPY at base 0.
    task automatic reset_boot(input string tag);
        int n;
        int dc0;
        wa_q.delete();
        wd_q.delete();
        dc0 = done_count;
        @(negedge clock);
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus.done !== 1'b1 && n < 200);
        // Done falls in the 20th cycle counting the release cycle as the first.
        check({tag, "_latency"}, 32'(n), 32'(IMG_WORDS + ROM_LAT + 1));
        check({tag, "_init_done"}, 32'(bus.init_done), 32'd1);
        post_load(1'b0, 8'h00, 8'h00, dc0, 1'b0, tag);
    endtask

    initial begin
        int n;
        for (int a = 0; a < 256; a++) begin
            mem[a] = 8'h00;
            exp_mem[a] = 8'h00;
        end
        reset = 1'b1;
        bus.start = 1'b0;
        bus.mode = 1'b0;
        bus.fill_value = 8'h00;
        bus.dst_base = 8'h00;
        bus.ext_addr = 8'h00;
        bus.ext_data = 8'h00;
        bus.ext_wren = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_outputs("por");

        // 1: automatic COPY after reset.
        reset_boot("t1_boot");
        check("t1_ram00", 32'(mem[8'h00]), 32'hA5);
        check("t1_ram0f", 32'(mem[8'h0F]), 32'hAA);

        // 2: FILL at 0x40.
        run_load(1'b1, 8'h3C, 8'h40, -1, 1'b0, "t2_fill");
        check("t2_ram4f", 32'(mem[8'h4F]), 32'h3C);

        // 3: COPY wrapping past the top of the address space.
        run_load(1'b0, 8'h00, 8'hF8, -1, 1'b0, "t3_wrap");
        check("t3_ramf8", 32'(mem[8'hF8]), 32'hA5);
        check("t3_ram07", 32'(mem[8'h07]), 32'hAA);

        // 4: external write held during a load.
        run_load(1'b0, 8'h00, 8'h40, -1, 1'b1, "t4_ext");

        // 5: second start during ISSUE is dropped.
        run_load(1'b0, 8'h00, 8'h80, 5, 1'b0, "t5_restart");

        // Random loads.
        for (int r = 0; r < 4; r++) begin
            run_load(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), -1, 1'b0, "rnd");
        end

        // 6: reset in the middle of a FILL.
        wa_q.delete();
        wd_q.delete();
        @(negedge clock);
        bus.start = 1'b1;
        bus.mode = 1'b1;
        bus.fill_value = 8'h3C;
        bus.dst_base = 8'h00;
        @(negedge clock);
        bus.start = 1'b0;
        n = 0;
        while (wa_q.size() < 7 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("t6_reach_word7", 32'(wa_q.size()), 32'd7);
        #2 reset = 1'b1;
        #1 check_reset_outputs("t6_abort");
        @(negedge clock);
        reset_boot("t6_boot");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
